// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source encodings, memory FSM states and default widths.
package cpu_pkg;

  localparam int unsigned DEFAULT_BIT_WIDTH           = 32;
  localparam int unsigned DEFAULT_REG_INDEX_BIT_WIDTH = 4;

  localparam logic [1:0] DST_ALU = 2'b00;
  localparam logic [1:0] DST_MEM = 2'b01;
  localparam logic [1:0] DST_PC  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_buffer.sv
// MEM/WB register bank: a plain enabled register primitive plus the bank that
// inserts a bubble (write enable cleared, other fields held) on stalled cycles.
module register_prim #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

module mem_wb_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned BIT_WIDTH           = DEFAULT_BIT_WIDTH,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bubble,
  input  logic [BIT_WIDTH-1:0]           data_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
  input  logic [1:0]                     dst_mux_in,
  input  logic                           reg_wrt_en_in,
  output logic [BIT_WIDTH-1:0]           data_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out,
  output logic [1:0]                     dst_mux_out,
  output logic                           reg_wrt_en_out
);

  localparam int unsigned W = BIT_WIDTH + REG_INDEX_BIT_WIDTH + 3;

  logic [W-1:0] d;
  logic [W-1:0] q;

  // Bubble keeps the payload fields and only drops the write enable.
  always_comb begin
    d = {data_in, dst_ind_in, dst_mux_in, reg_wrt_en_in};
    if (bubble) d = {q[W-1:1], 1'b0};
  end

  register_prim #(.WIDTH(W)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (d),
    .q     (q)
  );

  assign {data_out, dst_ind_out, dst_mux_out, reg_wrt_en_out} = q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data-memory handshake, stalls upstream
// while an access is outstanding, and registers results as the MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned BIT_WIDTH           = DEFAULT_BIT_WIDTH,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BIT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           alu_res_in,
  input  logic [BIT_WIDTH-1:0]           src1_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
  input  logic [1:0]                     dst_mux_in,
  input  logic                           mem_wrt_en_in,
  input  logic                           reg_file_wrt_en_in,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [BIT_WIDTH-1:0]           dmem_addr,
  output logic [BIT_WIDTH-1:0]           dmem_wdata,
  input  logic [BIT_WIDTH-1:0]           dmem_rdata,
  input  logic                           dmem_ready,
  output logic                           stall_out,
  output logic [BIT_WIDTH-1:0]           wb_data_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_dst_ind_out,
  output logic [1:0]                     wb_dst_mux_out,
  output logic                           wb_reg_wrt_en_out,
  output logic                           mem_err_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [BIT_WIDTH-1:0]           hold_addr, hold_wdata;
  logic [REG_INDEX_BIT_WIDTH-1:0] hold_dst_ind;
  logic [1:0]                     hold_dst_mux;
  logic                           hold_we, hold_is_load;

  logic is_load, is_store, access;
  logic req_c, we_c, capture, abort, bubble;
  logic [BIT_WIDTH-1:0]           wb_data_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_dst_ind_d;
  logic [1:0]                     wb_dst_mux_d;
  logic                           wb_reg_wrt_en_d;

  assign is_load  = reg_file_wrt_en_in && (dst_mux_in == DST_MEM);
  assign is_store = mem_wrt_en_in;
  assign access   = is_load || is_store;

  // Reset gates the request so a pending bus transaction is dropped at once.
  assign dmem_req = reset && req_c;
  assign dmem_we  = reset && we_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    req_c           = 1'b0;
    we_c            = 1'b0;
    dmem_addr       = alu_res_in;
    dmem_wdata      = src1_in;
    stall_out       = 1'b0;
    capture         = 1'b0;
    abort           = 1'b0;
    bubble          = 1'b0;
    wb_data_d       = alu_res_in;
    wb_dst_ind_d    = dst_ind_in;
    wb_dst_mux_d    = dst_mux_in;
    wb_reg_wrt_en_d = reg_file_wrt_en_in;
    case (state)
      IDLE: begin
        if (access) begin
          req_c           = 1'b1;
          we_c            = is_store;
          wb_reg_wrt_en_d = is_load;
          if (is_load) wb_data_d = dmem_rdata;
          if (!dmem_ready) begin
            stall_out = 1'b1;
            bubble    = 1'b1;
            capture   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req_c           = 1'b1;
        we_c            = hold_we;
        dmem_addr       = hold_addr;
        dmem_wdata      = hold_wdata;
        wb_data_d       = hold_is_load ? dmem_rdata : hold_addr;
        wb_dst_ind_d    = hold_dst_ind;
        wb_dst_mux_d    = hold_dst_mux;
        wb_reg_wrt_en_d = hold_is_load;
        if (dmem_ready) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort completes the access with zero read data.
          abort     = 1'b1;
          state_nxt = IDLE;
          if (hold_is_load) wb_data_d = '0;
        end else begin
          stall_out = 1'b1;
          bubble    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_dst_ind <= '0;
      hold_dst_mux <= '0;
      hold_we      <= 1'b0;
      hold_is_load <= 1'b0;
      mem_err_out  <= 1'b0;
    end else begin
      if (capture) begin
        hold_addr    <= alu_res_in;
        hold_wdata   <= src1_in;
        hold_dst_ind <= dst_ind_in;
        hold_dst_mux <= dst_mux_in;
        hold_we      <= is_store;
        hold_is_load <= is_load;
      end
      // Timeout counter runs only in WAIT and saturates instead of wrapping.
      if (state == IDLE)                       cnt <= '0;
      else if (cnt != CNT_W'(TIMEOUT_CYCLES))  cnt <= cnt + CNT_W'(1);
      if (abort) mem_err_out <= 1'b1;
    end
  end

  mem_wb_buffer #(
    .BIT_WIDTH           (BIT_WIDTH),
    .REG_INDEX_BIT_WIDTH (REG_INDEX_BIT_WIDTH)
  ) u_mem_wb_buffer (
    .clk            (clk),
    .rst_n          (reset),
    .bubble         (bubble),
    .data_in        (wb_data_d),
    .dst_ind_in     (wb_dst_ind_d),
    .dst_mux_in     (wb_dst_mux_d),
    .reg_wrt_en_in  (wb_reg_wrt_en_d),
    .data_out       (wb_data_out),
    .dst_ind_out    (wb_dst_ind_out),
    .dst_mux_out    (wb_dst_mux_out),
    .reg_wrt_en_out (wb_reg_wrt_en_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected write-back results,
// a negedge monitor pops and compares them whenever an op completes.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int unsigned T = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dst;
    logic [1:0]  mux;
    logic        wen;
  } wb_t;

  logic        clk, reset;
  logic [31:0] alu_res_in, src1_in, dmem_rdata, dmem_addr, dmem_wdata, wb_data_out;
  logic [3:0]  dst_ind_in, wb_dst_ind_out;
  logic [1:0]  dst_mux_in, wb_dst_mux_out;
  logic        mem_wrt_en_in, reg_file_wrt_en_in, dmem_ready;
  logic        dmem_req, dmem_we, stall_out, wb_reg_wrt_en_out, mem_err_out;

  int  checks = 0;
  int  fails  = 0;
  wb_t exp_q[$];
  wb_t last;
  bit  armed = 0;
  bit  took_prev = 0;
  bit  exp_err = 0;

  mem_stage #(.BIT_WIDTH(32), .REG_INDEX_BIT_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk), .reset (reset),
    .alu_res_in (alu_res_in), .src1_in (src1_in), .dst_ind_in (dst_ind_in),
    .dst_mux_in (dst_mux_in), .mem_wrt_en_in (mem_wrt_en_in),
    .reg_file_wrt_en_in (reg_file_wrt_en_in),
    .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
    .dmem_wdata (dmem_wdata), .dmem_rdata (dmem_rdata), .dmem_ready (dmem_ready),
    .stall_out (stall_out), .wb_data_out (wb_data_out), .wb_dst_ind_out (wb_dst_ind_out),
    .wb_dst_mux_out (wb_dst_mux_out), .wb_reg_wrt_en_out (wb_reg_wrt_en_out),
    .mem_err_out (mem_err_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an op accepted with stall_out low shows up on wb_* one edge later.
  always @(negedge clk) begin
    if (!reset) begin
      armed = 0;
      last  = '0;
    end else begin
      if (armed) begin
        if (took_prev) begin
          if (exp_q.size() == 0) begin
            chk("wb_unexpected_result", 32'd1, 32'd0);
          end else begin
            last = exp_q.pop_front();
            chk("wb_data", wb_data_out, last.data);
            chk("wb_dst_ind", 32'(wb_dst_ind_out), 32'(last.dst));
            chk("wb_dst_mux", 32'(wb_dst_mux_out), 32'(last.mux));
            chk("wb_reg_wrt_en", 32'(wb_reg_wrt_en_out), 32'(last.wen));
          end
        end else begin
          chk("bubble_wen", 32'(wb_reg_wrt_en_out), 32'd0);
          chk("bubble_hold_data", wb_data_out, last.data);
          chk("bubble_hold_dst", 32'(wb_dst_ind_out), 32'(last.dst));
        end
      end
      took_prev = !stall_out;
      armed     = 1;
    end
  end

  // Issue one op; lat is the presentation cycle in which memory answers (> T: never).
  task automatic do_op(input logic [31:0] alu, input logic [31:0] src, input logic [3:0] dst,
                       input logic [1:0] mux, input logic mwe, input logic ren,
                       input int unsigned lat, input logic [31:0] rdata);
    bit ld, st, acc;
    int unsigned fin;
    wb_t e;
    ld  = ren && (mux == DST_MEM);
    st  = mwe;
    acc = ld || st;
    fin = !acc ? 0 : (lat > T ? T : lat);
    e.data = ld ? ((lat > T) ? 32'd0 : rdata) : alu;
    e.dst  = dst;
    e.mux  = mux;
    e.wen  = acc ? ld : ren;
    exp_q.push_back(e);
    if (acc && lat > T) exp_err = 1;
    alu_res_in = alu; src1_in = src; dst_ind_in = dst; dst_mux_in = mux;
    mem_wrt_en_in = mwe; reg_file_wrt_en_in = ren;
    for (int c = 0; c <= int'(fin); c++) begin
      if (c > 0) begin
        alu_res_in = $urandom; src1_in = $urandom;
        dst_ind_in = 4'($urandom); dst_mux_in = 2'($urandom);
      end
      if (acc) begin
        dmem_ready = (c == int'(lat));
        dmem_rdata = (c == int'(lat)) ? rdata : $urandom;
      end else begin
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      chk("stall_out", 32'(stall_out), 32'(c < int'(fin)));
      chk("dmem_req", 32'(dmem_req), 32'(acc));
      if (acc) begin
        chk("dmem_addr", dmem_addr, alu);
        chk("dmem_wdata", dmem_wdata, src);
        chk("dmem_we", 32'(dmem_we), 32'(st));
      end
      @(posedge clk);
      #1;
    end
    if (acc) chk("mem_err", 32'(mem_err_out), 32'(exp_err));
  endtask

  task automatic idle_op();
    do_op($urandom, $urandom, 4'($urandom), 2'($urandom), 1'b0, 1'b0, 0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    alu_res_in = '0; src1_in = '0; dst_ind_in = '0; dst_mux_in = '0;
    mem_wrt_en_in = 0; reg_file_wrt_en_in = 0; dmem_ready = 0; dmem_rdata = '0;
    #3;
    chk("reset_wb_data", wb_data_out, 32'd0);
    chk("reset_wb_wen", 32'(wb_reg_wrt_en_out), 32'd0);
    chk("reset_mem_err", 32'(mem_err_out), 32'd0);
    chk("reset_dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_op(32'h1234, 32'h0, 4'd3, DST_ALU, 1'b0, 1'b1, 0, 32'h0);
    do_op(32'h40, 32'h0, 4'd5, DST_MEM, 1'b0, 1'b1, 0, 32'hDEADBEEF);
    do_op(32'h80, 32'hCAFE, 4'd7, DST_ALU, 1'b1, 1'b1, 3, 32'h0);
    do_op(32'h100, 32'h0, 4'd2, DST_MEM, 1'b0, 1'b1, T, 32'h5A5A5A5A);
    do_op(32'h104, 32'h0, 4'd9, DST_MEM, 1'b0, 1'b1, T - 1, 32'h0BADF00D);
    idle_op();
    do_op(32'h200, 32'h0, 4'd4, DST_MEM, 1'b0, 1'b1, 1000, 32'h11111111);
    do_op(32'h208, 32'h0, 4'd6, DST_MEM, 1'b0, 1'b1, 1, 32'h22222222);
    chk("mem_err_sticky", 32'(mem_err_out), 32'd1);

    // Reset in the middle of a waiting load.
    alu_res_in = 32'h300; src1_in = '0; dst_ind_in = 4'd8; dst_mux_in = DST_MEM;
    mem_wrt_en_in = 0; reg_file_wrt_en_in = 1; dmem_ready = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("wait_req_before_reset", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_err = 0;
    #1;
    chk("async_reset_req", 32'(dmem_req), 32'd0);
    chk("async_reset_wb_data", wb_data_out, 32'd0);
    chk("async_reset_wb_dst", 32'(wb_dst_ind_out), 32'd0);
    chk("async_reset_wb_mux", 32'(wb_dst_mux_out), 32'd0);
    chk("async_reset_wb_wen", 32'(wb_reg_wrt_en_out), 32'd0);
    chk("async_reset_mem_err", 32'(mem_err_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_op(32'hABCD, 32'h0, 4'd1, DST_ALU, 1'b0, 1'b1, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic mwe, ren;
      logic [1:0] mux;
      mwe = ($urandom_range(0, 3) == 0);
      ren = 1'($urandom);
      mux = ($urandom_range(0, 1) == 1) ? DST_MEM : 2'($urandom);
      if (mwe && ren && mux == DST_MEM) ren = 1'b0;
      do_op($urandom, $urandom, 4'($urandom), mux, mwe, ren,
            $urandom_range(0, 10), $urandom);
    end
    idle_op();

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
